// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter (message + isNew/ready handshake) between
// NUM_REQ requesters. One request is captured in IDLE and launched with a
// single-cycle tx_isNew pulse. The arbiter then waits for the transmitter
// to go busy (tx_ready=0) and return ready (tx_ready=1) before the next grant.
//
// Build option:
//   UART_TX_ARB_RR_EN defined   : round-robin arbitration; after reset,
//                                 requester 0 has first priority.
//   UART_TX_ARB_RR_EN undefined : fixed priority, lowest index wins.
//
// Ports:
//   clock       in   single clock
//   reset       in   asynchronous, active-high reset
//   req_valid   in   [NUM_REQ] per-requester request, held until req_ack
//   req_msg     in   [NUM_REQ*MSG_W] flattened messages, requester i at
//                    [i*MSG_W +: MSG_W]
//   req_ack     out  [NUM_REQ] one-hot, one-cycle launch acknowledge
//   tx_ready    in   transmitter idle/ready
//   tx_isNew    out  one-cycle launch pulse to the transmitter
//   tx_message  out  [MSG_W] launched message, held until the next launch
//   grant_id    out  [ID_W] index of the last granted requester
//   busy        out  high whenever the arbiter is not in IDLE

module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MSG_W   = 20,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]       req_ack,
  input  logic                     tx_ready,
  output logic                     tx_isNew,
  output logic [MSG_W-1:0]         tx_message,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t               state_q;
  logic                 tx_isNew_q;
  logic [NUM_REQ-1:0]   req_ack_q;
  logic [MSG_W-1:0]     tx_message_q;
  logic [ID_W-1:0]      grant_id_q;
  logic                 busy_q;

  logic                 win_any_c;
  logic [ID_W-1:0]      win_id_c;
  logic [MSG_W-1:0]     win_msg_c;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [ID_W-1:0] pick_lowest(input logic [NUM_REQ-1:0] vec);
    logic [ID_W-1:0] id;
    id = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (vec[i-1]) id = ID_W'(i - 1);
    end
    return id;
  endfunction

`ifdef UART_TX_ARB_RR_EN
  logic [ID_W-1:0]      last_q;
  logic [NUM_REQ-1:0]   hi_req_c;

  // Round robin: prefer requesters above the last grant, else wrap to the
  // lowest requester. last_q resets to NUM_REQ-1 so requester 0 leads.
  always_comb begin
    hi_req_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hi_req_c[i] = req_valid[i] && (ID_W'(i) > last_q);
    end
    win_id_c = (|hi_req_c) ? pick_lowest(hi_req_c) : pick_lowest(req_valid);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= ID_W'(NUM_REQ - 1);
    end else if (state_q == ST_IDLE && tx_ready && win_any_c) begin
      last_q <= win_id_c;
    end
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    win_id_c = pick_lowest(req_valid);
  end
`endif

  assign win_any_c = |req_valid;

  // Message mux for the selected requester.
  always_comb begin
    win_msg_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id_c) win_msg_c = req_msg[i*MSG_W +: MSG_W];
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tx_isNew_q   <= 1'b0;
      req_ack_q    <= '0;
      tx_message_q <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      tx_isNew_q <= 1'b0;
      req_ack_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (tx_ready && win_any_c) begin
            state_q      <= ST_LAUNCH;
            tx_isNew_q   <= 1'b1;
            req_ack_q    <= NUM_REQ'(1) << win_id_c;
            tx_message_q <= win_msg_c;
            grant_id_q   <= win_id_c;
            busy_q       <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // Transmitter must first report busy for this frame.
          if (!tx_ready) state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tx_ready) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_isNew   = tx_isNew_q;
  assign req_ack    = req_ack_q;
  assign tx_message = tx_message_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, MSG_W=20).
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned MSG_W   = 20;
  localparam int unsigned ID_W    = 2;

  logic                     clock;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic [NUM_REQ-1:0]       req_ack;
  logic                     tx_ready;
  logic                     tx_isNew;
  logic [MSG_W-1:0]         tx_message;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  logic [MSG_W-1:0] msg [NUM_REQ];

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .ID_W(ID_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_msg    (req_msg),
    .req_ack    (req_ack),
    .tx_ready   (tx_ready),
    .tx_isNew   (tx_isNew),
    .tx_message (tx_message),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Step until tx_isNew is seen or the cycle budget runs out.
  task automatic wait_launch(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tx_isNew && n < max_cyc);
    check({tag, "_launch_seen"}, 32'(tx_isNew), 32'd1);
  endtask

  task automatic check_grant(input string tag, input int id);
    check({tag, "_isnew"}, 32'(tx_isNew), 32'd1);
    check({tag, "_id"},    32'(grant_id), 32'(id));
    check({tag, "_ack"},   32'(req_ack), 32'(1 << id));
    check({tag, "_msg"},   32'(tx_message), 32'(msg[id]));
    check({tag, "_busy"},  32'(busy), 32'd1);
  endtask

  // Transmitter model: stays ready one cycle after launch, goes busy for
  // two cycles, then returns ready; the arbiter must land back in IDLE.
  task automatic finish_frame(input string tag);
    step();
    check({tag, "_no_dbl_isnew0"}, 32'(tx_isNew), 32'd0);
    check({tag, "_ack_cleared"},   32'(req_ack), 32'd0);
    tx_ready = 1'b0;
    step();
    check({tag, "_no_dbl_isnew1"}, 32'(tx_isNew), 32'd0);
    step();
    check({tag, "_busy_mid"}, 32'(busy), 32'd1);
    tx_ready = 1'b1;
    step();
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    msg[0] = 20'h0A0A0;
    msg[1] = 20'h11111;
    msg[2] = 20'h41424;
    msg[3] = 20'h33333;
    req_msg   = {msg[3], msg[2], msg[1], msg[0]};
    req_valid = '0;
    tx_ready  = 1'b0;
    reset     = 1'b1;
    step();
    step();

    // Reset values
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_isnew", 32'(tx_isNew), 32'd0);
    check("rst_ack",   32'(req_ack), 32'd0);
    check("rst_msg",   32'(tx_message), 32'd0);
    check("rst_id",    32'(grant_id), 32'd0);
    reset = 1'b0;
    step();

    // Single request on requester 2
    tx_ready  = 1'b1;
    req_valid = 4'b0100;
    step();
    check_grant("single", 2);
    req_valid = 4'b0000;
    finish_frame("single");
    check("single_msg_held", 32'(tx_message), 32'h41424);

    // All four requesting, each withdrawing after its ack
    apply_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_launch("all4", 8);
      check_grant($sformatf("all4_g%0d", k), k);
      req_valid[k] = 1'b0;
      finish_frame($sformatf("all4_f%0d", k));
    end

`ifdef UART_TX_ARB_RR_EN
    // Wrap-around after granting 3: {3,1} -> 1 then 3
    req_valid = 4'b1010;
    wait_launch("rrwrap1", 8);
    check_grant("rrwrap1", 1);
    req_valid[1] = 1'b0;
    finish_frame("rrwrap1");
    wait_launch("rrwrap3", 8);
    check_grant("rrwrap3", 3);
    req_valid[3] = 1'b0;
    finish_frame("rrwrap3");
`else
    // Fixed priority: 1 keeps winning over 3 while it requests
    req_valid = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      wait_launch("fp1", 8);
      check_grant($sformatf("fp1_r%0d", k), 1);
      finish_frame($sformatf("fp1_f%0d", k));
    end
    req_valid[1] = 1'b0;
    wait_launch("fp3", 8);
    check_grant("fp3", 3);
    req_valid[3] = 1'b0;
    finish_frame("fp3");
`endif

    // Ready gating: 10 cycles of tx_ready=0 with a pending request
    tx_ready  = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("gate_isnew%0d", k), 32'(tx_isNew), 32'd0);
      check($sformatf("gate_ack%0d", k),   32'(req_ack), 32'd0);
    end
    tx_ready = 1'b1;
    step();
    check_grant("gate_rel", 0);
    req_valid = 4'b0000;
    finish_frame("gate_rel");

    // Reset in WAIT_DONE
    req_valid = 4'b0100;
    step();
    check_grant("midrst", 2);
    req_valid = 4'b0000;
    step();
    tx_ready = 1'b0;
    step();
    check("midrst_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_msg",   32'(tx_message), 32'd0);
    check("midrst_isnew", 32'(tx_isNew), 32'd0);
    check("midrst_ack",   32'(req_ack), 32'd0);
    step();
    reset     = 1'b0;
    tx_ready  = 1'b1;
    req_valid = 4'b0101;
    step();
    check_grant("postrst", 0);
    req_valid = 4'b0100;
    finish_frame("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
